ps2_keyboard_fifo: RTL
======================

# ps2_keyboard_fifo

Parametrised PS/2 keyboard receiver with decoded key-event buffering. It deserialises PS/2 frames, checks them, and folds the E0/F0 prefixes into single make/break events. Events are queued in a show-ahead FIFO. It also keeps a raw-byte history register that can drive the 8-digit hex display in board-level testers. It is the successor to the plain keyboard receiver: it adds framing and parity checking, a timeout, event decoding and buffering, and sticky error flags.

## Interface
- NBYTES, 4: raw-byte history depth; `keyb_char` is 8*NBYTES bits wide.
- DEPTH, 8: event FIFO depth. Must be a power of 2, at least 2.
- TIMEOUT_CYCLES, 50000: `clock` cycles allowed between PS/2 clock falling edges inside a frame (1 ms at 50 MHz).
- clock  in  1  system clock, 50 MHz; every register is clocked on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  PS/2 clock, asynchronous.
- ps2_data  in  1  PS/2 data, asynchronous.
- rd_en  in  1  pops the FIFO head when `empty`=0. Ignored when `empty`=1.
- clr_err  in  1  clears `overflow`, `parity_err` and `frame_err`.
- rd_data  out  10  FIFO head: {brk, ext, code[7:0]}. Valid whenever `empty`=0.
- empty  out  1  FIFO holds no events.
- full  out  1  FIFO holds DEPTH events.
- count  out  $clog2(DEPTH+1)  number of events held.
- keyb_char  out  8*NBYTES  history of valid bytes; newest byte in [7:0].
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- parity_err  out  1  sticky: a frame failed the odd-parity check.
- frame_err  out  1  sticky: bad stop bit, or a timeout in mid-frame.

## Operation
- Input conditioning:
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser.
  - A falling edge is the cycle in which the synchronised clock goes from 1 (previous cycle) to 0.
  - Data is sampled only on falling-edge cycles.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a falling edge with data=0 (start bit), go to DATA with bit count 0. A start bit of 1 is ignored and the FSM stays in IDLE.
  - DATA: shift in 8 bits, LSB first. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: on the falling edge, check stop=1 and odd parity over the 8 data bits plus the parity bit, then return to IDLE.
- Timeout:
  - A counter clears on every falling edge.
  - If the FSM is outside IDLE and the counter reaches TIMEOUT_CYCLES, the FSM returns to IDLE and `frame_err` sets.
- Frame outcomes:
  - Parity failure: the byte is discarded and `parity_err` sets.
  - Stop failure: the byte is discarded and `frame_err` sets.
  - If both fail, both flags set.
  - Any discarded frame also clears the pending ext/brk prefix flags.
- Valid byte handling:
  - `keyb_char` shifts left by 8 and the new byte enters [7:0].
  - 0xE0 sets the pending ext flag. 0xF0 sets the pending brk flag. Neither pushes an event.
  - Any other byte pushes {brk, ext, byte} and then clears both prefix flags.
- FIFO:
  - Circular buffer with write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - `count` tracks occupancy.
  - Push while full and no pop: the event is dropped and `overflow` sets.
  - Push and pop in the same cycle: both happen and `count` is unchanged. This holds when full, so the push is accepted and no overflow occurs.
  - Pop while empty: no effect.
- Error flags:
  - `clr_err` clears all three sticky flags.
  - If a new error and `clr_err` occur in the same cycle, the flag ends up set.

## Timing
- Reset values:
  - `empty`=1.
  - `full`=0, `count`=0, `rd_data`=0, `keyb_char`=0.
  - All three error flags 0.
  - FSM in IDLE, prefix flags 0, pointers 0, timeout counter 0.
  - Synchroniser flops reset to 1.
- Reset in the middle of a frame aborts the frame. Nothing is pushed, and no error flag is set.
- Latency: the stop-bit falling edge is detected in cycle E. In cycle E+1:
  - `keyb_char` is updated.
  - The event is written into the FIFO.
  - `count`, `empty`, `full` and (if the FIFO was empty) `rd_data` reflect the push.
- The external pin-to-detection delay is 2 synchroniser cycles plus 1 edge-detect cycle.
- Pop: with `rd_en`=1 in cycle P, the next entry appears on `rd_data` and `count` decrements in cycle P+1.
- Error flags set in cycle E+1 of the failing frame. A timeout sets `frame_err` on the cycle after the counter reaches TIMEOUT_CYCLES.

## Test plan
- Frame 0x1C (parity 0, stop 1) → `count`=1, `rd_data`=0x01C, `keyb_char`=0x0000001C. No error flags.
- Bytes E0, F0, 75 → exactly one event, 0x375, and `keyb_char`=0x00E0F075. Then F0, 1C → event 0x21C.
- Frame 0x1C with parity bit 1 → `parity_err`=1 and no event. A following E0 then 74 gives 0x174, showing the prefix still works after the discarded frame. `clr_err` → flag returns to 0.
- Start bit plus 4 data bits, then clock idle for TIMEOUT_CYCLES+2 → `frame_err`=1 and FSM back in IDLE. A following full 0x1C frame is received correctly.
- DEPTH=8: send 9 codes 0x10..0x18 → `full`=1, `count`=8, `overflow`=1. Popping 8 times yields 0x010..0x017 in order, then `empty`=1.
- With the FIFO full, `rd_en` held high in the push cycle of a 10th code → `count` stays 8 and `overflow` is not newly set. Separately, `reset` asserted after the 5th data bit → all outputs return to their reset values and a following frame decodes correctly.

Source files
------------

// File: rtl/ps2_keyboard_fifo.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deserialises and checks
// frames, folds E0/F0 prefixes into make/break events, queues the events in a
// show-ahead FIFO and keeps a shift history of every valid raw byte.
module ps2_keyboard_fifo #(
  parameter int unsigned NBYTES         = 4,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         ps2_clk,
  input  logic                         ps2_data,
  input  logic                         rd_en,
  input  logic                         clr_err,
  output logic [9:0]                   rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [8*NBYTES-1:0]          keyb_char,
  output logic                         overflow,
  output logic                         parity_err,
  output logic                         frame_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, clk_prev, fall;
  logic          dat_s1, dat_s2, dat_smp;
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] timer;
  logic          ext_pend, brk_pend;

  logic          tmo, stop_done, par_bad, stop_bad, byte_ok, is_e0, is_f0;
  logic          push, pop, wr_ok, ovf_set;
  logic [9:0]    push_data;
  logic [8*NBYTES-1:0] kc_next;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  // Two-flop synchronisers followed by a registered falling-edge detect; the
  // data sample is delayed alongside so it lines up with the edge strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      dat_smp  <= 1'b1;
      fall     <= 1'b0;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
      dat_smp  <= dat_s2;
      fall     <= clk_prev & ~clk_s2;
    end
  end

  // Frame outcome decode for the current cycle.
  always_comb begin
    tmo       = (state != IDLE) && (timer == TMO_MAX) && !fall;
    stop_done = fall && (state == STOP);
    par_bad   = stop_done && !(^{shreg, par_bit});
    stop_bad  = stop_done && !dat_smp;
    byte_ok   = stop_done && !par_bad && !stop_bad;
    is_e0     = (shreg == 8'hE0);
    is_f0     = (shreg == 8'hF0);
    push      = byte_ok && !is_e0 && !is_f0;
    push_data = {brk_pend, ext_pend, shreg};
    kc_next   = keyb_char << 8;
    kc_next[7:0] = shreg;
  end

  // Frame FSM with inter-edge timeout counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      timer   <= '0;
    end else begin
      if (fall || state == IDLE) timer <= '0;
      else if (timer != TMO_MAX) timer <= timer + 1'b1;

      if (tmo) begin
        state <= IDLE;
      end else if (fall) begin
        case (state)
          IDLE: if (!dat_smp) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            shreg   <= {dat_smp, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= dat_smp;
            state   <= STOP;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Raw-byte history and E0/F0 prefix tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      keyb_char <= '0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
    end else if (byte_ok) begin
      keyb_char <= kc_next;
      if (is_e0) ext_pend <= 1'b1;
      else if (is_f0) brk_pend <= 1'b1;
      else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end else if (par_bad || stop_bad || tmo) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end
  end

  // A push into a full FIFO is still accepted when a pop frees a slot.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CNT_FULL);
    pop     = rd_en && !empty;
    wr_ok   = push && (!full || pop);
    ovf_set = push && full && !pop;
    rd_data = empty ? '0 : mem[rptr];
  end

  // Event storage.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wptr] <= push_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      overflow   <= (overflow   & ~clr_err) | ovf_set;
      parity_err <= (parity_err & ~clr_err) | par_bad;
      frame_err  <= (frame_err  & ~clr_err) | stop_bad | tmo;
    end
  end

endmodule
